// File: rtl/tdm_deframer_pkg.sv
// tdm_pkg: shared types and checks for the TDM deframer.
//   state_t     - framing state (HUNT, LOCK)
//   LEGAL_CH    - the channel counts the demux stage can be built for
//   ch_is_legal - constant function used to reject unsupported CH values
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int LEGAL_CH [3] = '{2, 4, 8};

  function automatic bit ch_is_legal(input int ch);
    return (ch == LEGAL_CH[0]) || (ch == LEGAL_CH[1]) || (ch == LEGAL_CH[2]);
  endfunction

endpackage

// File: rtl/tdm_deframer_if.sv
// tdm_deframer_if: serial-in / frame-out bus of the TDM deframer.
//   y, en, fsync        - serial bit, bit strobe, frame marker (source -> deframer)
//   sel                 - current channel select (deframer -> demux / source)
//   o, frame_valid      - last complete frame and its one-cycle update pulse
//   locked, sync_err    - framing status
// Modports: master = bit source side, slave = deframer side.
interface tdm_deframer_if #(
  parameter int CH = 8
) ();
  localparam int SEL_W = $clog2(CH);

  logic             y;
  logic             en;
  logic             fsync;
  logic [SEL_W-1:0] sel;
  logic [CH-1:0]    o;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  modport master (
    output y, en, fsync,
    input  sel, o, frame_valid, locked, sync_err
  );

  modport slave (
    input  y, en, fsync,
    output sel, o, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_deframer_demux.sv
// 1:N demultiplexers that steer one input bit to the output picked by sel.
// The deframer feeds them with the bit strobe, so their one-hot outputs
// act as per-channel write enables.
//   demux1_2: y, sel (1 bit), scalar outputs o0/o1
//   demux1_4: y, sel (2 bits), o[3:0]
//   demux1_8: y, sel (3 bits), o[7:0]
module demux1_2 (
  input  logic y,
  input  logic sel,
  output logic o0,
  output logic o1
);
  assign o0 = y & ~sel;
  assign o1 = y & sel;
endmodule

module demux1_4 (
  input  logic       y,
  input  logic [1:0] sel,
  output logic [3:0] o
);
  assign o = {3'b000, y} << sel;
endmodule

module demux1_8 (
  input  logic       y,
  input  logic [2:0] sel,
  output logic [7:0] o
);
  assign o = {7'b000_0000, y} << sel;
endmodule

// File: rtl/tdm_deframer.sv
// tdm_deframer: serial TDM deframer. Hunts for the frame marker, then steps
// the channel select once per bit strobe, collects bits into a shadow word
// and publishes a complete CH-bit frame on o with a one-cycle frame_valid.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - tdm_deframer_if.slave (y, en, fsync in; sel, o, frame_valid,
//          locked, sync_err out)
// Parameter CH: 2, 4 or 8 channels.
// Build option TDM_SYNC_CHECK_EN: when defined, misplaced or missing fsync
// in LOCK raises sync_err and realigns / drops back to HUNT; otherwise LOCK
// free-runs and sync_err is tied low.
import tdm_pkg::*;

module tdm_deframer #(
  parameter int CH = 8
) (
  input  logic          clk,
  input  logic          rst,
  tdm_deframer_if.slave bus
);
  localparam int SEL_W = $clog2(CH);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  if (!ch_is_legal(CH)) begin : g_ch_check
    $error("tdm_deframer: CH must be 2, 4 or 8");
  end

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [CH-1:0]    shadow, shadow_n;
  logic [CH-1:0]    o_q, o_n;
  logic             fv_q, fv_n;
  logic [CH-1:0]    we;

  // The strobe demuxed by the current select gives the shadow write enable.
  if (CH == 2) begin : g_dmx2
    demux1_2 u_demux (.y(bus.en), .sel(sel_q), .o0(we[0]), .o1(we[1]));
  end else if (CH == 4) begin : g_dmx4
    demux1_4 u_demux (.y(bus.en), .sel(sel_q), .o(we));
  end else begin : g_dmx8
    demux1_8 u_demux (.y(bus.en), .sel(sel_q), .o(we));
  end

`ifdef TDM_SYNC_CHECK_EN
  logic err_q, err_n;
`endif

  // Next-state logic: hunting for the marker, then a flywheel over channels.
  always_comb begin
    state_n  = state;
    sel_n    = sel_q;
    shadow_n = shadow;
    o_n      = o_q;
    fv_n     = 1'b0;
`ifdef TDM_SYNC_CHECK_EN
    err_n    = 1'b0;
`endif
    case (state)
      HUNT: begin
        if (bus.en && bus.fsync) begin
          shadow_n[0] = bus.y;
          sel_n       = SEL_ONE;
          state_n     = LOCK;
        end
      end
      LOCK: begin
        if (bus.en) begin
`ifdef TDM_SYNC_CHECK_EN
          if (bus.fsync && (sel_q != '0)) begin
            // Marker arrived early: abandon this frame and restart at channel 0.
            err_n       = 1'b1;
            shadow_n[0] = bus.y;
            sel_n       = SEL_ONE;
          end else if (!bus.fsync && (sel_q == '0)) begin
            // Marker missing at a frame boundary: lose lock, drop the bit.
            err_n   = 1'b1;
            state_n = HUNT;
          end else
`endif
          begin
            for (int k = 0; k < CH; k++) begin
              if (we[k]) shadow_n[k] = bus.y;
            end
            if (sel_q == SEL_LAST) begin
              o_n   = shadow_n;
              fv_n  = 1'b1;
              sel_n = '0;
            end else begin
              sel_n = sel_q + 1'b1;
            end
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HUNT;
      sel_q  <= '0;
      shadow <= '0;
      o_q    <= '0;
      fv_q   <= 1'b0;
`ifdef TDM_SYNC_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      sel_q  <= sel_n;
      shadow <= shadow_n;
      o_q    <= o_n;
      fv_q   <= fv_n;
`ifdef TDM_SYNC_CHECK_EN
      err_q  <= err_n;
`endif
    end
  end

  assign bus.sel         = sel_q;
  assign bus.o           = o_q;
  assign bus.frame_valid = fv_q;
  assign bus.locked      = (state == LOCK);
`ifdef TDM_SYNC_CHECK_EN
  assign bus.sync_err    = err_q;
`else
  assign bus.sync_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_deframer.sv
// tb_tdm_deframer: directed, table-driven bench for tdm_deframer (CH=8).
// Each vector drives one cycle of inputs and lists the outputs expected
// just after the next rising edge. A hand-written stream afterwards checks
// the frame_valid spacing at full rate. Follows TDM_SYNC_CHECK_EN.
module tb_tdm_deframer;

  logic clk = 1'b0;
  logic rst;

  tdm_deframer_if #(.CH(8)) bus ();

  tdm_deframer #(.CH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         rst, en, fsync, y;
    logic [2:0] sel;
    logic [7:0] o;
    bit         fv, lk, err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Append one cycle of stimulus and its expected response.
  task automatic add(input string nm, input bit r, input bit e, input bit f, input bit yy,
                     input int s, input logic [7:0] oo, input bit fv, input bit lk, input bit er);
    vec_t v;
    v.name = nm; v.rst = r; v.en = e; v.fsync = f; v.y = yy;
    v.sel = 3'(s); v.o = oo; v.fv = fv; v.lk = lk; v.err = er;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic apply_stimulus(input bit r, input bit e, input bit f, input bit yy);
    rst       = r;
    bus.en    = e;
    bus.fsync = f;
    bus.y     = yy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Add a full frame with fsync on channel 0; prev is o before completion.
  task automatic add_frame(input string nm, input logic [7:0] val, input logic [7:0] prev);
    for (int i = 0; i < 8; i++)
      add(nm, 0, 1, i == 0, val[i], (i + 1) % 8, (i == 7) ? val : prev, i == 7, 1, 0);
  endtask

  initial begin
    logic [7:0] v;
    int         pulses;
    int         pulse_cyc[$];
    logic [7:0] stream[3];

    rst = 1'b1; bus.en = 1'b0; bus.fsync = 1'b0; bus.y = 1'b0;

    // Reset, then lock onto 1,0,1,1,0,0,1,0 -> 8'b0100_1101.
    add("reset", 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add("reset", 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add_frame("lock", 8'h4D, 8'h00);
    add("idle", 0, 0, 1, 1, 0, 8'h4D, 0, 1, 0);

    // Back-to-back frames at full rate.
    add_frame("b2b_a5", 8'hA5, 8'h4D);
    add_frame("b2b_3c", 8'h3C, 8'hA5);
    add_frame("b2b_ff", 8'hFF, 8'h3C);

    // Gapped strobes: en toggles, sel only moves on strobes.
    v = 8'h81;
    for (int i = 0; i < 8; i++) begin
      add("gap", 0, 1, i == 0, v[i], (i + 1) % 8, (i == 7) ? v : 8'hFF, i == 7, 1, 0);
      add("gap_idle", 0, 0, 0, ~v[i], (i + 1) % 8, (i == 7) ? v : 8'hFF, 0, 1, 0);
    end

    // Mid-frame reset at sel=4, reset beats a simultaneous strobe.
    for (int i = 0; i < 4; i++)
      add("pre_rst", 0, 1, i == 0, 1, i + 1, 8'h81, 0, 1, 0);
    add("mid_rst", 1, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    add("hunt_nosync", 0, 1, 0, 1, 0, 8'h00, 0, 0, 0);
    add_frame("relock", 8'h3C, 8'h00);

    // Misplaced sync at sel=5.
    for (int i = 0; i < 5; i++)
      add("pre_mis", 0, 1, i == 0, 0, i + 1, 8'h3C, 0, 1, 0);
`ifdef TDM_SYNC_CHECK_EN
    add("mis_sync", 0, 1, 1, 1, 1, 8'h3C, 0, 1, 1);
    v = 8'h5B;
    for (int i = 1; i < 8; i++)
      add("realign", 0, 1, 0, v[i], (i + 1) % 8, (i == 7) ? v : 8'h3C, i == 7, 1, 0);
    add("miss_sync", 0, 1, 0, 0, 0, 8'h5B, 0, 0, 1);
    add("hunt_drop", 0, 1, 0, 1, 0, 8'h5B, 0, 0, 0);
`else
    add("mis_sync", 0, 1, 1, 1, 6, 8'h3C, 0, 1, 0);
    add("unalign", 0, 1, 0, 1, 7, 8'h3C, 0, 1, 0);
    add("unalign", 0, 1, 0, 1, 0, 8'hE0, 1, 1, 0);
    add("no_sync", 0, 1, 0, 0, 1, 8'hE0, 0, 1, 0);
`endif

    foreach (vecs[n]) begin
      apply_stimulus(vecs[n].rst, vecs[n].en, vecs[n].fsync, vecs[n].y);
      check_output({vecs[n].name, ".sel"}, 8'(bus.sel), 8'(vecs[n].sel));
      check_output({vecs[n].name, ".o"}, bus.o, vecs[n].o);
      check_output({vecs[n].name, ".frame_valid"}, 8'(bus.frame_valid), 8'(vecs[n].fv));
      check_output({vecs[n].name, ".locked"}, 8'(bus.locked), 8'(vecs[n].lk));
      check_output({vecs[n].name, ".sync_err"}, 8'(bus.sync_err), 8'(vecs[n].err));
    end

    // Full-rate stream of three frames: pulses must be exactly 8 cycles apart.
    stream = '{8'h96, 8'h69, 8'hC3};
    apply_stimulus(1, 0, 0, 0);
    pulses = 0;
    for (int f = 0; f < 3; f++) begin
      v = stream[f];
      for (int i = 0; i < 8; i++) begin
        apply_stimulus(0, 1, i == 0, v[i]);
        if (bus.frame_valid) begin
          pulses++;
          pulse_cyc.push_back(cyc);
          check_output("stream.o_at_pulse", bus.o, v);
        end
      end
    end
    apply_stimulus(0, 0, 0, 0);
    check_output("stream.fv_drop", 8'(bus.frame_valid), 8'h00);
    check_output("stream.pulses", 8'(pulses), 8'd3);
    if (pulse_cyc.size() == 3) begin
      check_output("stream.gap1", 8'(pulse_cyc[1] - pulse_cyc[0]), 8'd8);
      check_output("stream.gap2", 8'(pulse_cyc[2] - pulse_cyc[1]), 8'd8);
    end
    check_output("stream.o_final", bus.o, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
